// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle controller.
//   - opcode constants (IR[31:26])
//   - UC_signal encodings consumed by alu_control
//   - 4-bit state enum (state_o debug encoding)
//   - opcode class enum produced by mc_opcode_decode
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [2:0] {
    UC_RTYPE = 3'b000,
    UC_ADD   = 3'b001,
    UC_SUB   = 3'b010,
    UC_AND   = 3'b011,
    UC_OR    = 3'b100,
    UC_SLT   = 3'b101
  } uc_e;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    WB_R     = 4'd4,
    EXEC_I   = 4'd5,
    WB_I     = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD   = 4'd8,
    WB_MEM   = 4'd9,
    MEM_WR   = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    TRAP     = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_MEM,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_IMM,
    CLS_ILLEGAL
  } op_class_e;

  // States that issue a memory request and wait on mem_ready.
  function automatic logic is_mem_state(input state_e s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// mc_opcode_decode: combinational opcode classifier.
// Ports:
//   opcode   in  [5:0]  IR[31:26]
//   op_class out        next-state class taken out of DECODE
//   imm_uc   out        ALU class for I-type arithmetic (ADD for anything else)
module mc_opcode_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_e  op_class,
  output uc_e        imm_uc
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    imm_uc   = UC_ADD;
    case (opcode)
      OP_RTYPE:    op_class = CLS_R;
      OP_LW,
      OP_SW:       op_class = CLS_MEM;
      OP_BEQ:      op_class = CLS_BRANCH;
      OP_J:        op_class = CLS_JUMP;
      OP_ADDI: begin
        op_class = CLS_IMM;
        imm_uc   = UC_ADD;
      end
      OP_ANDI: begin
        op_class = CLS_IMM;
        imm_uc   = UC_AND;
      end
      OP_ORI: begin
        op_class = CLS_IMM;
        imm_uc   = UC_OR;
      end
      OP_SLTI: begin
        op_class = CLS_IMM;
        imm_uc   = UC_SLT;
      end
      default:     op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS-like datapath.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | halted, waiting for run
// FETCH    | read instruction memory, PC+4 on mem_ready
// DECODE   | register read, branch target into ALUOut
// EXEC_R   | R-type ALU op
// WB_R     | write rd
// EXEC_I   | I-type ALU op with sign-extended immediate
// WB_I     | write rt
// MEM_ADDR | compute load/store address
// MEM_RD   | data memory read, wait for mem_ready
// WB_MEM   | write loaded data to rt
// MEM_WR   | data memory write, wait for mem_ready
// BRANCH   | BEQ compare, PC <- ALUOut when zero
// JUMP     | PC <- jump target
// TRAP     | illegal opcode or memory timeout; held until rst
//
// Parameter MEM_TIMEOUT: max wait cycles per memory state (0 = no timeout).
// Ports: clk, rst (sync, active-high), run, opcode[5:0], zero, mem_ready in;
//   datapath strobes/selects, UC_signal[2:0], trap, state_o[3:0] out.
// Optional: MULTICYCLE_CONTROL_PERF_EN adds instr_count[31:0] (completed
//   instructions, wrapping).
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_b,
  output logic [2:0] UC_signal,
  output logic       trap,
  output logic [3:0] state_o
`ifdef MULTICYCLE_CONTROL_PERF_EN
  ,
  output logic [31:0] instr_count
`endif
);

  localparam int unsigned CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned CNT_INIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_INIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_hit;
  logic             instr_done;
  op_class_e        op_class;
  uc_e              imm_uc;

  mc_opcode_decode u_decode (
    .opcode   (opcode),
    .op_class (op_class),
    .imm_uc   (imm_uc)
  );

  // Down-counter reaches terminal count on the last allowed wait cycle;
  // a miss of mem_ready there is the timeout.
  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    instr_done = 1'b0;
    case (state_q)
      IDLE:     if (run) state_d = FETCH;
      FETCH: begin
        if (mem_ready)        state_d = DECODE;
        else if (timeout_hit) state_d = TRAP;
      end
      DECODE: begin
        case (op_class)
          CLS_R:      state_d = EXEC_R;
          CLS_MEM:    state_d = MEM_ADDR;
          CLS_BRANCH: state_d = BRANCH;
          CLS_JUMP:   state_d = JUMP;
          CLS_IMM:    state_d = EXEC_I;
          default:    state_d = TRAP;
        endcase
      end
      EXEC_R:   state_d = WB_R;
      EXEC_I:   state_d = WB_I;
      MEM_ADDR: state_d = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (mem_ready)        state_d = WB_MEM;
        else if (timeout_hit) state_d = TRAP;
      end
      MEM_WR: begin
        if (mem_ready)        instr_done = 1'b1;
        else if (timeout_hit) state_d = TRAP;
      end
      WB_R, WB_I, WB_MEM, BRANCH, JUMP: instr_done = 1'b1;
      TRAP:     state_d = TRAP;
      default:  state_d = TRAP;
    endcase
    if (instr_done) state_d = run ? FETCH : IDLE;
  end

  // Reload on every entry into a memory state, including FETCH after a
  // completed MEM_WR; count down only while the request is outstanding.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (is_mem_state(state_d) && (state_d != state_q))
      wait_cnt_d = CNT_LOAD;
    else if (is_mem_state(state_q) && !mem_ready && (wait_cnt_q != '0))
      wait_cnt_d = wait_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    pc_src     = 2'b00;
    alu_src_b  = 2'b00;
    UC_signal  = UC_RTYPE;
    trap       = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        UC_signal = UC_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        UC_signal = UC_ADD;
      end
      EXEC_R: alu_src_a = 1'b1;
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        UC_signal = imm_uc;
      end
      WB_I:   reg_write = 1'b1;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        UC_signal = UC_ADD;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        UC_signal = UC_SUB;
        pc_src    = 2'b01;
        pc_write  = zero;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      TRAP:    trap = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

`ifdef MULTICYCLE_CONTROL_PERF_EN
  logic [31:0] instr_count_q, instr_count_d;

  assign instr_count_d = instr_done ? instr_count_q + 32'd1 : instr_count_q;

  always_ff @(posedge clk) begin
    if (rst) instr_count_q <= '0;
    else     instr_count_q <= instr_count_d;
  end

  assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control.
// The stimulus process walks each instruction through the sequence of
// phases it must visit and pushes the expected output vector per cycle;
// a monitor pops and compares on every falling edge.
module tb_multicycle_control;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_WB_R = 4,
                 S_EXEC_I = 5, S_WB_I = 6, S_MEM_ADDR = 7, S_MEM_RD = 8,
                 S_WB_MEM = 9, S_MEM_WR = 10, S_BRANCH = 11, S_JUMP = 12, S_TRAP = 13;

  logic clk = 1'b0;
  logic rst = 1'b1, run = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src_a, trap;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] UC_signal;
  logic [3:0] state_o;
`ifdef MULTICYCLE_CONTROL_PERF_EN
  logic [31:0] instr_count;
`endif

  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .UC_signal(UC_signal), .trap(trap), .state_o(state_o)
`ifdef MULTICYCLE_CONTROL_PERF_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [21:0] exp_q[$];
  int in_idle = 1;
  int model_count = 0;

  wire [21:0] act = {state_o, trap, mem_req, mem_we, iord, ir_write, pc_write, reg_write,
                     reg_dst, mem_to_reg, alu_src_a, pc_src, alu_src_b, UC_signal};

  // 0 R, 1 LW, 2 SW, 3 BEQ, 4 J, 5 I-arith, 6 illegal
  function automatic int op_kind(input logic [5:0] opc);
    case (opc)
      6'b000000: return 0;
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b000010: return 4;
      6'b001000, 6'b001100, 6'b001101, 6'b001010: return 5;
      default:   return 6;
    endcase
  endfunction

  function automatic logic [21:0] exp_vec(input int st, input logic [5:0] opc,
                                          input logic z, input logic rdy);
    logic tr = 0, mr = 0, we = 0, io = 0, irw = 0, pcw = 0, rw = 0, rd = 0, m2r = 0, sa = 0;
    logic [1:0] ps = 0, sb = 0;
    logic [2:0] uc = 0;
    case (st)
      S_FETCH:    begin mr = 1; sb = 2'b01; uc = 3'b001; irw = rdy; pcw = rdy; end
      S_DECODE:   begin sb = 2'b11; uc = 3'b001; end
      S_EXEC_R:   begin sa = 1; end
      S_WB_R:     begin rw = 1; rd = 1; end
      S_EXEC_I: begin
        sa = 1; sb = 2'b10;
        case (opc)
          6'b001100: uc = 3'b011;
          6'b001101: uc = 3'b100;
          6'b001010: uc = 3'b101;
          default:   uc = 3'b001;
        endcase
      end
      S_WB_I:     rw = 1;
      S_MEM_ADDR: begin sa = 1; sb = 2'b10; uc = 3'b001; end
      S_MEM_RD:   begin mr = 1; io = 1; end
      S_WB_MEM:   begin rw = 1; m2r = 1; end
      S_MEM_WR:   begin mr = 1; we = 1; io = 1; end
      S_BRANCH:   begin sa = 1; uc = 3'b010; ps = 2'b01; pcw = z; end
      S_JUMP:     begin ps = 2'b10; pcw = 1; end
      S_TRAP:     tr = 1;
      default:    ;
    endcase
    return {4'(st), tr, mr, we, io, irw, pcw, rw, rd, m2r, sa, ps, sb, uc};
  endfunction

  // One clock of stimulus; st < 0 means no expectation for this cycle.
  task automatic cycle(input logic r, input logic rn, input logic [5:0] opc,
                       input logic z, input logic rdy, input int st);
    @(posedge clk);
    #1;
    rst = r; run = rn; opcode = opc; zero = z; mem_ready = rdy;
    if (st >= 0) exp_q.push_back(exp_vec(st, opc, z, rdy));
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic mem_phase(input int st, input logic [5:0] opc, input logic z,
                           input int waits, input logic last_run);
    for (int i = 0; i < waits; i++) cycle(0, rb(), opc, z, 0, st);
    cycle(0, last_run, opc, z, 1, st);
  endtask

  task automatic do_instr(input logic [5:0] opc, input logic z, input int fw,
                          input int mw, input logic run_after, input int trap_hold);
    int k;
    k = op_kind(opc);
    if (in_idle != 0) cycle(0, 1, opc, z, rb(), S_IDLE);
    mem_phase(S_FETCH, opc, z, fw, rb());
    cycle(0, rb(), opc, z, rb(), S_DECODE);
    case (k)
      0: begin cycle(0, rb(), opc, z, rb(), S_EXEC_R); cycle(0, run_after, opc, z, rb(), S_WB_R); end
      1: begin
        cycle(0, rb(), opc, z, rb(), S_MEM_ADDR);
        mem_phase(S_MEM_RD, opc, z, mw, rb());
        cycle(0, run_after, opc, z, rb(), S_WB_MEM);
      end
      2: begin
        cycle(0, rb(), opc, z, rb(), S_MEM_ADDR);
        mem_phase(S_MEM_WR, opc, z, mw, run_after);
      end
      3: cycle(0, run_after, opc, z, rb(), S_BRANCH);
      4: cycle(0, run_after, opc, z, rb(), S_JUMP);
      5: begin cycle(0, rb(), opc, z, rb(), S_EXEC_I); cycle(0, run_after, opc, z, rb(), S_WB_I); end
      default: begin
        for (int i = 0; i < trap_hold; i++) cycle(0, rb(), opc, rb(), rb(), S_TRAP);
        cycle(1, 0, opc, z, 0, S_TRAP);
        in_idle = 1;
        model_count = 0;
      end
    endcase
    if (k != 6) begin
      model_count++;
      in_idle = run_after ? 0 : 1;
    end
  endtask

`ifdef MULTICYCLE_CONTROL_PERF_EN
  // Only called after an instruction finished with run=0, so the DUT sits
  // in IDLE while this extra cycle elapses.
  task automatic check_count();
    @(posedge clk);
    #2;
    vectors++;
    if (instr_count !== 32'(model_count)) begin
      miscompares++;
      $display("FAIL instr_count got=%0d exp=%0d", instr_count, model_count);
    end
  endtask
`endif

  initial begin : monitor
    logic [21:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (act !== e)
          begin
            miscompares++;
            $display("FAIL outputs t=%0t got state=%0d vec=%h exp state=%0d vec=%h",
                     $time, act[21:18], act, e[21:18], e);
          end
      end
    end
  end

  initial begin : stim
    logic [5:0] legal_ops [9];
    logic [5:0] opc;
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                  6'b001000, 6'b001100, 6'b001101, 6'b001010};
    cycle(1, 0, 0, 0, 0, -1);
    cycle(1, 0, 0, 0, 0, -1);
    in_idle = 1;
    model_count = 0;

    // R-type with immediate memory, then LW with 3 wait cycles in MEM_RD
    do_instr(6'b000000, 0, 0, 0, 1, 0);
    do_instr(6'b100011, 0, 0, 3, 1, 0);
    // BEQ taken / not taken, ORI, J, SW
    do_instr(6'b000100, 1, 0, 0, 1, 0);
    do_instr(6'b000100, 0, 1, 0, 1, 0);
    do_instr(6'b001101, 0, 0, 0, 1, 0);
    do_instr(6'b000010, 0, 2, 0, 1, 0);
    do_instr(6'b101011, 0, 0, 2, 0, 0);
`ifdef MULTICYCLE_CONTROL_PERF_EN
    check_count();
`endif
    // illegal opcode: trap held 20 cycles then reset
    do_instr(6'b111111, 0, 0, 0, 1, 20);

    // fetch timeout: 4 cycles without mem_ready -> TRAP
    cycle(0, 1, 0, 0, 0, S_IDLE);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, S_FETCH);
    for (int i = 0; i < 3; i++) cycle(0, rb(), 0, 0, rb(), S_TRAP);
    cycle(1, 0, 0, 0, 0, S_TRAP);
    in_idle = 1;
    model_count = 0;

    // reset in the middle of a MEM_WR wait
    cycle(0, 1, 6'b101011, 0, 0, S_IDLE);
    cycle(0, 1, 6'b101011, 0, 1, S_FETCH);
    cycle(0, 1, 6'b101011, 0, 0, S_DECODE);
    cycle(0, 1, 6'b101011, 0, 0, S_MEM_ADDR);
    cycle(0, 1, 6'b101011, 0, 0, S_MEM_WR);
    cycle(1, 1, 6'b101011, 0, 0, S_MEM_WR);
    in_idle = 1;
    model_count = 0;

    // five back-to-back instructions, run dropped during the fifth
    do_instr(6'b001000, 0, 0, 0, 1, 0);
    do_instr(6'b100011, 0, 1, 1, 1, 0);
    do_instr(6'b001010, 0, 0, 0, 1, 0);
    do_instr(6'b000100, 1, 0, 0, 1, 0);
    do_instr(6'b001100, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, S_IDLE);
    cycle(0, 0, 0, 0, 0, S_IDLE);
`ifdef MULTICYCLE_CONTROL_PERF_EN
    check_count();
`endif

    // randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        do opc = 6'($urandom); while (op_kind(opc) != 6);
      end else begin
        opc = legal_ops[$urandom_range(0, 8)];
      end
      do_instr(opc, rb(), $urandom_range(0, 3), $urandom_range(0, 3),
               (n == 79) ? 1'b0 : 1'($urandom_range(0, 3) != 0), $urandom_range(1, 5));
    end
`ifdef MULTICYCLE_CONTROL_PERF_EN
    check_count();
`endif

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
